// File: rtl/disp_sr_rx_pkg.sv
// Shared display shift-register interface constants.
package disp_sr_rx_pkg;

    localparam int unsigned DISP_WIDTH = 256;
    localparam int unsigned DISP_CNT_W = $clog2(DISP_WIDTH + 2);
    localparam int unsigned DISP_FRM_W = 16;

    typedef logic [DISP_CNT_W-1:0] disp_cnt_t;

endpackage

// File: rtl/disp_rx_sync.sv
// N-stage input synchronizer with a registered rising-edge detector.
module disp_rx_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              level_q;
    logic              rise_q;

    // level_q doubles as the edge-detect history, so level_o and rise_o stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d_i};
            level_q <= sync_q[STAGES-1];
            rise_q  <= sync_q[STAGES-1] & ~level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/disp_sr_rx.sv
// Display shift-register receiver: rebuilds latched frames, checks bit counts,
// counts good frames and flags loss of frames via a ms watchdog.
module disp_sr_rx
    import disp_sr_rx_pkg::*;
#(
    parameter int unsigned WIDTH       = DISP_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOST_MS     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tsc_1ppms,
    input  logic                  disp_sclk,
    input  logic                  disp_lat,
    input  logic                  disp_sin,
    output logic [WIDTH-1:0]      rx_data,
    output logic                  rx_valid,
    output logic                  rx_err,
    output logic [8:0]            rx_bits,
    output logic [DISP_FRM_W-1:0] rx_frames,
    output logic                  rx_lost
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 2);
    localparam int unsigned MS_W  = $clog2(LOST_MS + 1);

    logic sclk_rise, lat_rise, sin_lvl;
    logic sclk_lvl_unused, lat_lvl_unused, sin_rise_unused;

    disp_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (disp_sclk),
        .level_o(sclk_lvl_unused),
        .rise_o (sclk_rise)
    );

    disp_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_lat (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (disp_lat),
        .level_o(lat_lvl_unused),
        .rise_o (lat_rise)
    );

    disp_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sin (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (disp_sin),
        .level_o(sin_lvl),
        .rise_o (sin_rise_unused)
    );

    logic [WIDTH-1:0]      sr_q, sr_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]      rx_data_q, rx_data_d;
    logic [8:0]            rx_bits_q, rx_bits_d;
    logic [DISP_FRM_W-1:0] rx_frames_q, rx_frames_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_err_q, rx_err_d;
    logic [MS_W-1:0]       ms_cnt_q, ms_cnt_d;
    logic                  rx_lost_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_bits_q   <= '0;
            rx_frames_q <= '0;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            ms_cnt_q    <= '0;
            rx_lost_q   <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_bits_q   <= rx_bits_d;
            rx_frames_q <= rx_frames_d;
            rx_valid_q  <= rx_valid_d;
            rx_err_q    <= rx_err_d;
            ms_cnt_q    <= ms_cnt_d;
            rx_lost_q   <= (ms_cnt_d == MS_W'(LOST_MS));
        end
    end

    // Close the old frame before accounting a same-cycle sclk bit to the new one.
    always_comb begin
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_bits_d   = rx_bits_q;
        rx_frames_d = rx_frames_q;
        rx_valid_d  = 1'b0;
        rx_err_d    = 1'b0;
        ms_cnt_d    = ms_cnt_q;

        if (lat_rise) begin
            rx_bits_d = 9'(bit_cnt_q);
            bit_cnt_d = '0;
            if (bit_cnt_q == CNT_W'(WIDTH)) begin
                rx_data_d   = sr_q;
                rx_valid_d  = 1'b1;
                rx_frames_d = rx_frames_q + DISP_FRM_W'(1);
            end else if (bit_cnt_q != '0) begin
                rx_err_d = 1'b1;
            end
        end

        if (sclk_rise) begin
            sr_d = {sr_q[WIDTH-2:0], sin_lvl};
            if (bit_cnt_d != CNT_W'(WIDTH + 1)) begin
                bit_cnt_d = bit_cnt_d + CNT_W'(1);
            end
        end

        // A good frame clears the watchdog even if a tick lands in the same cycle.
        if (rx_valid_q) begin
            ms_cnt_d = '0;
        end else if (tsc_1ppms && (ms_cnt_q != MS_W'(LOST_MS))) begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_err    = rx_err_q;
    assign rx_bits   = rx_bits_q;
    assign rx_frames = rx_frames_q;
    assign rx_lost   = rx_lost_q;

endmodule

// File: tb/tb_disp_sr_rx.sv
// Directed bench for disp_sr_rx with a frame-level reference model checked every cycle.
module tb_disp_sr_rx;
    import disp_sr_rx_pkg::*;

    localparam int unsigned W    = DISP_WIDTH;
    localparam int unsigned SYNC = 2;
    localparam int unsigned LOST = 3;
    localparam int unsigned LAT  = SYNC + 2;
    localparam int unsigned H    = SYNC + 1;

    logic clk = 1'b0, rst_n = 1'b0, tsc = 1'b0, sclk = 1'b0, lat = 1'b0, sin = 1'b0;
    logic [W-1:0] rx_data;
    logic         rx_valid, rx_err, rx_lost;
    logic [8:0]   rx_bits;
    logic [15:0]  rx_frames;

    disp_sr_rx #(.WIDTH(W), .SYNC_STAGES(SYNC), .LOST_MS(LOST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tsc_1ppms(tsc),
        .disp_sclk(sclk),
        .disp_lat (lat),
        .disp_sin (sin),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rx_bits  (rx_bits),
        .rx_frames(rx_frames),
        .rx_lost  (rx_lost)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int vcount   = 0;
    int ecount   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: bits seen since the last latch, one pending frame close.
    bit           sent_q[$];
    logic         pend = 1'b0;
    int           pend_due;
    logic         pend_valid, pend_err;
    int           pend_bits;
    logic [W-1:0] pend_data;

    logic [W-1:0] e_data   = '0;
    int           e_bits   = 0;
    logic [15:0]  e_frames = '0;
    logic         e_valid  = 1'b0;
    logic         e_err    = 1'b0;
    logic         e_lost   = 1'b0;
    logic         prev_v;
    int           ms       = 0;

    task automatic close_frame();
        int n;
        n          = sent_q.size();
        pend_due   = cyc + LAT;
        pend_bits  = (n > W + 1) ? W + 1 : n;
        pend_valid = (n == W);
        pend_err   = (n != W) && (n != 0);
        pend_data  = '0;
        if (n == W) begin
            for (int i = 0; i < W; i++) pend_data[W-1-i] = sent_q[i];
        end
        sent_q.delete();
        pend = 1'b1;
    endtask

    // Cycle-by-cycle compare, sampled 1 time unit after each rising clock edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            prev_v  = e_valid;
            e_valid = 1'b0;
            e_err   = 1'b0;
            if (!rst_n) begin
                e_data = '0; e_bits = 0; e_frames = '0; ms = 0; e_lost = 1'b0; pend = 1'b0;
            end else begin
                if (pend && cyc == pend_due) begin
                    e_valid = pend_valid;
                    e_err   = pend_err;
                    e_bits  = pend_bits;
                    if (pend_valid) begin
                        e_data   = pend_data;
                        e_frames = e_frames + 16'd1;
                    end
                    pend = 1'b0;
                end
                if (prev_v) ms = 0;
                else if (tsc && ms < LOST) ms++;
                e_lost = (ms == LOST);
            end
            if (rx_valid === 1'b1) vcount++;
            if (rx_err === 1'b1) ecount++;
            chk("rx_valid", W'(rx_valid), W'(e_valid));
            chk("rx_err", W'(rx_err), W'(e_err));
            chk("rx_data", rx_data, e_data);
            chk("rx_bits", W'(rx_bits), W'(e_bits));
            chk("rx_frames", W'(rx_frames), W'(e_frames));
            chk("rx_lost", W'(rx_lost), W'(e_lost));
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        sin = b;
        wait_n(H);
        sclk = 1'b1;
        sent_q.push_back(b);
        wait_n(H);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input int n);
        for (int i = 0; i < n; i++) send_bit((i < W) ? d[W-1-i] : 1'b0);
    endtask

    task automatic pulse_lat();
        lat = 1'b1;
        close_frame();
        wait_n(H);
        lat = 1'b0;
        wait_n(H);
    endtask

    task automatic tick();
        tsc = 1'b1;
        wait_n(1);
        tsc = 1'b0;
        wait_n(2);
    endtask

    logic [W-1:0] pat  = {8{32'h5ABCCE1C}};
    logic [W-1:0] pat2 = {8{32'hC3A50F96}};
    logic [W-1:0] rnd, one_msb;
    int           due;

    initial begin
        wait_n(3);
        rst_n = 1'b1;
        wait_n(2);
        chk("reset_bits", W'(rx_bits), W'(0));
        chk("reset_lost", W'(rx_lost), W'(0));

        // Idle latch, then a good frame published by the next latch.
        pulse_lat();
        chk("idle_lat_bits", W'(rx_bits), W'(0));
        chk("idle_lat_nopulse", W'(vcount + ecount), W'(0));
        send_frame(pat, 256);
        pulse_lat();
        chk("good_data", rx_data, pat);
        chk("good_bits", W'(rx_bits), W'(256));
        chk("good_frames", W'(rx_frames), W'(1));
        chk("good_vcount", W'(vcount), W'(1));

        // Short and long frames.
        send_frame(~pat, 255);
        pulse_lat();
        chk("short_err", W'(ecount), W'(1));
        chk("short_bits", W'(rx_bits), W'(255));
        chk("short_data_held", rx_data, pat);
        send_frame(~pat, 300);
        pulse_lat();
        chk("long_err", W'(ecount), W'(2));
        chk("long_bits", W'(rx_bits), W'(257));
        chk("long_frames", W'(rx_frames), W'(1));

        // Back-to-back random frames, each published by the following latch.
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < W / 32; j++) rnd[j*32 +: 32] = $urandom;
            send_frame(rnd, 256);
            pulse_lat();
            chk("loop_data", rx_data, rnd);
            chk("loop_frames", W'(rx_frames), W'(2 + f));
        end
        chk("loop_no_err", W'(ecount), W'(2));

        // Latch and sclk rising together: the bit belongs to the new frame.
        send_frame(pat2, 256);
        sin = 1'b1;
        wait_n(H);
        lat  = 1'b1;
        sclk = 1'b1;
        close_frame();
        sent_q.push_back(1'b1);
        wait_n(H);
        lat  = 1'b0;
        sclk = 1'b0;
        wait_n(H);
        chk("simul_data", rx_data, pat2);
        send_frame('0, 255);
        pulse_lat();
        one_msb = '0;
        one_msb[W-1] = 1'b1;
        chk("simul_next_data", rx_data, one_msb);
        chk("simul_next_bits", W'(rx_bits), W'(256));

        // Watchdog rises after the third tick, clears after a good frame.
        tick();
        tick();
        chk("wd_two_ticks", W'(rx_lost), W'(0));
        tick();
        chk("wd_lost", W'(rx_lost), W'(1));
        send_frame(pat, 256);
        pulse_lat();
        chk("wd_cleared", W'(rx_lost), W'(0));

        // Tick in the same cycle as rx_valid: the clear wins.
        tick();
        send_frame(pat2, 256);
        lat = 1'b1;
        close_frame();
        due = pend_due;
        while (cyc < due) wait_n(1);
        tsc = 1'b1;
        wait_n(1);
        tsc = 1'b0;
        lat = 1'b0;
        wait_n(H);
        tick();
        tick();
        chk("wd_sametick_clear", W'(rx_lost), W'(0));
        tick();
        chk("wd_sametick_lost", W'(rx_lost), W'(1));

        // Reset in the middle of a frame.
        send_frame(pat, 100);
        rst_n = 1'b0;
        sent_q.delete();
        wait_n(2);
        chk("rst_data", rx_data, '0);
        chk("rst_frames", W'(rx_frames), W'(0));
        chk("rst_lost", W'(rx_lost), W'(0));
        rst_n = 1'b1;
        wait_n(2);
        due = vcount + ecount;
        pulse_lat();
        chk("rst_lat_bits", W'(rx_bits), W'(0));
        chk("rst_lat_nopulse", W'(vcount + ecount), W'(due));
        send_frame(pat, 256);
        pulse_lat();
        chk("rst_good_data", rx_data, pat);
        chk("rst_good_frames", W'(rx_frames), W'(1));

        wait_n(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got cyc %0d expected under 200000", cyc);
        $fatal(1);
    end

endmodule

// File: doc/disp_sr_rx.md
# disp_sr_rx

Serial receiver for the display shift-register interface (disp_sclk / disp_lat / disp_sin). It reconstructs each 256-bit frame exactly as the display driver chips would latch it and reports frame integrity. It sits on the loopback/self-test path of the clock design, fed either from the pins or directly from the display transmitter outputs, and lets firmware and benches read back what the display actually received.

## Interface
- WIDTH, 256: frame length in bits; must match the transmitter.
- SYNC_STAGES, 2: synchronizer depth on the three serial inputs (≥2).
- LOST_MS, 3: number of tsc_1ppms ticks without a good frame before rx_lost asserts.

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tsc_1ppms  in  1  1-cycle ms tick from the TSC, used by the watchdog.
- disp_sclk  in  1  serial clock; data is sampled on its rising edge.
- disp_lat  in  1  latch; a rising edge closes the current frame.
- disp_sin  in  1  serial data, MSB (bit WIDTH-1) first.
- rx_data  out  WIDTH  last good frame, held until the next good frame.
- rx_valid  out  1  1-cycle pulse when rx_data updates.
- rx_err  out  1  1-cycle pulse when a frame closes with a bad bit count.
- rx_bits  out  9  bit count of the most recently closed frame; saturates at WIDTH+1.
- rx_frames  out  16  good-frame counter; wraps modulo 2^16.
- rx_lost  out  1  level; high when no good frame arrived within LOST_MS ms.

## Operation
- All three inputs pass through identical SYNC_STAGES flop chains, so their relative alignment is preserved. Edge detection uses one extra flop per input.
- Shift: on a synchronized sclk rising edge, sr <= {sr[WIDTH-2:0], sin_sync}, and bit_cnt increments, saturating at WIDTH+1. The first bit received ends up in rx_data[WIDTH-1].
- Frame close happens on a synchronized lat rising edge:
  - bit_cnt == WIDTH: rx_data <= sr, pulse rx_valid, increment rx_frames.
  - bit_cnt == 0: idle latch. No pulse. rx_bits still updates to 0.
  - Any other count: pulse rx_err. rx_data is unchanged.
  - In all cases: rx_bits <= bit_cnt, and bit_cnt restarts.
- Semantics match the transmitter: lat precedes the bits of a frame. Frame N's data is therefore published at the lat that starts frame N+1, as the display chips do.
- Watchdog: ms_cnt increments on tsc_1ppms, saturating at LOST_MS. rx_lost = (ms_cnt == LOST_MS). The counter clears on rx_valid.
- Simultaneous events:
  - lat edge and sclk edge in the same cycle: close the old frame first. That sclk bit becomes bit 1 of the new frame (bit_cnt = 1, shifted into sr).
  - rx_valid and tsc_1ppms in the same cycle: clear wins (ms_cnt = 0).
- Reset (asynchronous, any time, including mid-frame) clears sr, bit_cnt, synchronizers, rx_data, rx_bits, rx_frames, ms_cnt, rx_valid and rx_err to 0. No partial frame survives.
- Reset values: rx_lost = 0 and ms_cnt = 0. The first frame after reset is never reported valid, because its latch sees bit_cnt = 0.

## Timing
- Pin-to-output latency: a lat rising edge at the input produces rx_valid/rx_err SYNC_STAGES+2 clk cycles later. rx_data, rx_bits and rx_frames update in that same cycle.
- Minimum sclk high and low time: SYNC_STAGES+1 clk cycles. Narrower pulses may be missed. The transmitter's 1 µs half-periods satisfy this.
- sin is sampled on the synchronized cycle of the sclk edge. The transmitter holds sin stable for ≥1 µs around the rising edge.
- rx_lost rises in the cycle after the LOST_MS-th tick and falls in the cycle after rx_valid.

## Structure
- The shared display package holds:
  - DISP_WIDTH = 256, used as the default for WIDTH in both transmitter and receiver.
  - The bit-count width, $clog2(DISP_WIDTH+2).
- One sub-module, disp_rx_sync: a parameterised N-stage synchronizer plus rising-edge detector, instantiated three times.
- Frame logic, counters and watchdog live in the top module; no FSM beyond bit_cnt/ms_cnt is needed.

## Test plan
- **Good frame:** reset, lat, 256 bits of pattern 0x…BCCE1C, then lat. Expect rx_valid once, rx_data = pattern, rx_bits = 256, rx_frames = 1.
- **Short and long frames:** 255 bits then lat → rx_err, rx_bits = 255, rx_data unchanged. 300 bits then lat → rx_err, rx_bits = 257.
- **Loopback:** connect to the display transmitter with random disp_data each ms for 20 ms. rx_data must equal the disp_data loaded one ms earlier. rx_err is never pulsed.
- **Simultaneous edges:** drive lat and sclk rising in the same cycle after 256 bits. Expect rx_valid, and the new frame's bit_cnt = 1 with that bit at sr[0].
- **Watchdog:** stop frames and send 3 ms ticks. rx_lost rises after the 3rd tick and clears one cycle after the next rx_valid. Same-cycle tick and rx_valid → ms_cnt = 0.
- **Mid-frame reset:** assert rst_n low after 100 bits. All outputs go to 0. The next lat reports nothing; the following 256-bit frame is valid.
